top_fetch: RTL and testbench
============================

// Module: top_fetch
// PURPOSE
//   Fetch stage of the 5-stage RV32I pipeline. Owns the PC register and talks to the instruction memory.
//   It uses a req/ready handshake with variable latency, and holds the IF/ID pipeline register.
//   It consumes the redirect (PCsrc_E, PCTarget_E) that the execute stage produces.
//   It honours stall/flush from the hazard unit and feeds instr/PC to decode.
// PARAMETERS
//   DATA_WIDTH  32            data/address width
//   RESET_PC    32'h0000_0000 PC value loaded on reset
// PORTS
//   clk          in   1           clock, rising edge
//   rst          in   1           asynchronous reset, active-high
//   PCsrc_E      in   1           redirect request from execute
//   PCTarget_E   in   DATA_WIDTH  redirect target; bits[1:0] forced to 0
//   stall        in   1           freezes PC_F and IF/ID register
//   flush_D      in   1           turns IF/ID into a bubble next edge
//   imem_req     out  1           instruction request valid
//   imem_addr    out  DATA_WIDTH  request address; stable while imem_req=1 and imem_ready=0
//   imem_ready   in   1           response valid this cycle (ends request)
//   imem_rdata   in   32          instruction word, valid when imem_ready=1
//   instr_D      out  32          IF/ID instruction
//   PC_D         out  DATA_WIDTH  IF/ID PC
//   PCPlus4_D    out  DATA_WIDTH  IF/ID PC+4
//   valid_D      out  1           IF/ID holds a real instruction
// BEHAVIOUR
//   Reset (async, while rst=1):
//     PC_F=RESET_PC, state=FETCH, imem_req=0, instr_D=32'h00000013 (NOP).
//     PC_D=0, PCPlus4_D=0, valid_D=0. Hold buffer is empty.
//   States: FETCH, DISCARD, HOLD.
//   imem_req=1 in FETCH and DISCARD (rst=0). imem_addr=PC_F in FETCH and the latched old address in DISCARD.
//   FETCH, imem_ready=1:
//     if PCsrc_E: drop the response; PC_F<=PCTarget_E; stay in FETCH.
//     elif stall: capture imem_rdata and PC_F into the hold buffer; go to HOLD.
//     else: IF/ID<={imem_rdata, PC_F, PC_F+4, 1}; PC_F<=PC_F+4.
//     Zero-wait memory gives 1 instr/cycle.
//   FETCH, imem_ready=0:
//     if PCsrc_E: latch the old address; PC_F<=PCTarget_E; go to DISCARD. The address must not change mid-request.
//   DISCARD: wait for imem_ready, drop the response, then go to FETCH at PC_F.
//     A further PCsrc_E here overwrites PC_F; the last redirect wins.
//   HOLD: imem_req=0.
//     if PCsrc_E: drop the buffer; PC_F<=PCTarget_E; go to FETCH.
//     elif !stall: IF/ID<=buffer (valid=1); PC_F<=buffered PC+4; go to FETCH.
//   IF/ID update priority per edge: flush_D > stall > load.
//     flush_D: instr_D=NOP, valid_D=0, PC_D/PCPlus4_D unchanged.
//     stall: IF/ID holds.
//     No load in the cycle: valid_D<=0 unless stall.
//   Redirect (PCsrc_E) always has priority over stall for PC_F.
//     The hazard unit asserts flush_D with PCsrc_E; this block does not flush on its own.
//   PC arithmetic is modulo 2^DATA_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
//   Reset mid-DISCARD/HOLD returns to FETCH at RESET_PC. The pending response is not delivered.
//   Latency: response edge -> instr_D valid after 1 clk.
// TESTING
//   1. Reset, ready tied 1: imem_addr 0,4,8,12 on consecutive cycles; instr_D follows 1 cycle later; valid_D=1.
//   2. Ready after 3 cycles: imem_addr holds 0x0 for 3 cycles; one IF/ID load; PC_F becomes 0x4.
//   3. stall=1 at the response edge for 0x8: go to HOLD, req=0.
//      Drop stall: instr_D=word@0x8, next addr=0xC, nothing lost or duplicated.
//   4. PCsrc_E=1, target 0x43 while waiting on 0x10: imem_addr stays 0x10 until ready.
//      Response dropped; next request at 0x40.
//   5. flush_D with load in the same edge: instr_D=0x00000013, valid_D=0. PC still advances.
//   6. rst pulsed mid-DISCARD: imem_req drops at once. After release the first addr is RESET_PC and the old response is ignored.

Source files
------------

// File: rtl/top_fetch.sv
// Fetch stage: PC register, variable-latency instruction memory handshake
// and the IF/ID pipeline register. A redirect that arrives while a request is
// outstanding is remembered and the late response is dropped.
module top_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCsrc_E,
    input  logic [DATA_WIDTH-1:0] PCTarget_E,
    input  logic                  stall,
    input  logic                  flush_D,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr_D,
    output logic [DATA_WIDTH-1:0] PC_D,
    output logic [DATA_WIDTH-1:0] PCPlus4_D,
    output logic                  valid_D
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] pc_f, pc_nx, pc_plus4, target;
    logic [DATA_WIDTH-1:0] old_addr, hold_pc;
    logic [31:0]           hold_instr;
    logic                  hold_cap, old_cap;
    logic                  ld;
    logic [31:0]           ld_instr;
    logic [DATA_WIDTH-1:0] ld_pc;

    assign target   = PCTarget_E & ~DATA_WIDTH'(3);
    assign pc_plus4 = pc_f + DATA_WIDTH'(4);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // Next state, next PC and buffer capture strobes; redirect beats stall
    always_comb begin
        state_nx = state;
        pc_nx    = pc_f;
        hold_cap = 1'b0;
        old_cap  = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (PCsrc_E) begin
                        pc_nx = target;
                    end else if (stall) begin
                        hold_cap = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        pc_nx = pc_plus4;
                    end
                end else if (PCsrc_E) begin
                    old_cap  = 1'b1;
                    pc_nx    = target;
                    state_nx = DISCARD;
                end
            end
            DISCARD: begin
                if (PCsrc_E)    pc_nx    = target;
                if (imem_ready) state_nx = FETCH;
            end
            HOLD: begin
                if (PCsrc_E) begin
                    pc_nx    = target;
                    state_nx = FETCH;
                end else if (!stall) begin
                    pc_nx    = hold_pc + DATA_WIDTH'(4);
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    // Memory request outputs and IF/ID load selection
    always_comb begin
        imem_req  = !rst && (state != HOLD);
        imem_addr = (state == DISCARD) ? old_addr : pc_f;
        ld        = 1'b0;
        ld_instr  = imem_rdata;
        ld_pc     = pc_f;
        if (state == FETCH && imem_ready && !PCsrc_E && !stall) begin
            ld = 1'b1;
        end else if (state == HOLD && !PCsrc_E && !stall) begin
            ld       = 1'b1;
            ld_instr = hold_instr;
            ld_pc    = hold_pc;
        end
    end

    // PC, address latch and hold buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f       <= RESET_PC;
            old_addr   <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            pc_f <= pc_nx;
            if (old_cap) old_addr <= pc_f;
            if (hold_cap) begin
                hold_pc    <= pc_f;
                hold_instr <= imem_rdata;
            end
        end
    end

    // IF/ID register: flush > stall > load; an unloaded cycle leaves a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_D   <= NOP;
            PC_D      <= '0;
            PCPlus4_D <= '0;
            valid_D   <= 1'b0;
        end else if (flush_D) begin
            instr_D <= NOP;
            valid_D <= 1'b0;
        end else if (!stall) begin
            if (ld) begin
                instr_D   <= ld_instr;
                PC_D      <= ld_pc;
                PCPlus4_D <= ld_pc + DATA_WIDTH'(4);
                valid_D   <= 1'b1;
            end else begin
                valid_D <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_top_fetch.sv
// Directed-vector bench for top_fetch: a table of per-cycle inputs and
// expected outputs, followed by hand sequences for reset-in-DISCARD and PC wrap.
module tb_top_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCsrc_E = 1'b0;
    logic [31:0] PCTarget_E = '0;
    logic        stall = 1'b0;
    logic        flush_D = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_D, PC_D, PCPlus4_D;
    logic        valid_D;

    int nvec = 0;
    int nerr = 0;

    top_fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCsrc_E(PCsrc_E), .PCTarget_E(PCTarget_E),
        .stall(stall), .flush_D(flush_D), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_D(instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, pcsrc, stall, flush, ready;
        logic [31:0] target, rdata;
        bit          e_req;
        logic [31:0] e_addr, e_instr, e_pcd, e_pc4;
        bit          e_valid;
    } vec_t;

    vec_t tbl[26];

    function automatic logic [31:0] I(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit req, input logic [31:0] addr,
                           input logic [31:0] ins, input logic [31:0] pcd,
                           input logic [31:0] pc4, input bit vld);
        chk({tag, " req"},   {31'd0, imem_req}, {31'd0, req});
        chk({tag, " addr"},  imem_addr, addr);
        chk({tag, " instr"}, instr_D, ins);
        chk({tag, " PC_D"},  PC_D, pcd);
        chk({tag, " PC4_D"}, PCPlus4_D, pc4);
        chk({tag, " valid"}, {31'd0, valid_D}, {31'd0, vld});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          rst pcs stl fls rdy target        rdata         req addr          instr     PC_D          PC4           vld
        tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,   NOP,      32'h0,   32'h0,   0};
        tbl[1]  = '{0, 0, 0, 0, 1, 32'h0,        I(32'h0),     1, 32'h0,   NOP,      32'h0,   32'h0,   0};
        tbl[2]  = '{0, 0, 0, 0, 1, 32'h0,        I(32'h4),     1, 32'h4,   I(32'h0), 32'h0,   32'h4,   1};
        tbl[3]  = '{0, 0, 0, 0, 1, 32'h0,        I(32'h8),     1, 32'h8,   I(32'h4), 32'h4,   32'h8,   1};
        tbl[4]  = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         1, 32'hC,   I(32'h8), 32'h8,   32'hC,   1};
        tbl[5]  = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         1, 32'hC,   I(32'h8), 32'h8,   32'hC,   0};
        tbl[6]  = '{0, 0, 0, 0, 1, 32'h0,        I(32'hC),     1, 32'hC,   I(32'h8), 32'h8,   32'hC,   0};
        tbl[7]  = '{0, 0, 1, 0, 1, 32'h0,        I(32'h10),    1, 32'h10,  I(32'hC), 32'hC,   32'h10,  1};
        tbl[8]  = '{0, 0, 1, 0, 0, 32'h0,        JUNK,         0, 32'h10,  I(32'hC), 32'hC,   32'h10,  1};
        tbl[9]  = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         0, 32'h10,  I(32'hC), 32'hC,   32'h10,  1};
        tbl[10] = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         1, 32'h14,  I(32'h10),32'h10,  32'h14,  1};
        tbl[11] = '{0, 1, 0, 1, 0, 32'h43,       JUNK,         1, 32'h14,  I(32'h10),32'h10,  32'h14,  0};
        tbl[12] = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         1, 32'h14,  NOP,      32'h10,  32'h14,  0};
        tbl[13] = '{0, 0, 0, 0, 1, 32'h0,        I(32'h14),    1, 32'h14,  NOP,      32'h10,  32'h14,  0};
        tbl[14] = '{0, 0, 0, 1, 1, 32'h0,        I(32'h40),    1, 32'h40,  NOP,      32'h10,  32'h14,  0};
        tbl[15] = '{0, 0, 0, 0, 1, 32'h0,        I(32'h44),    1, 32'h44,  NOP,      32'h10,  32'h14,  0};
        tbl[16] = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         1, 32'h48,  I(32'h44),32'h44,  32'h48,  1};
        tbl[17] = '{0, 1, 0, 0, 0, 32'h100,      JUNK,         1, 32'h48,  I(32'h44),32'h44,  32'h48,  0};
        tbl[18] = '{0, 1, 0, 0, 0, 32'h200,      JUNK,         1, 32'h48,  I(32'h44),32'h44,  32'h48,  0};
        tbl[19] = '{0, 0, 0, 0, 1, 32'h0,        JUNK,         1, 32'h48,  I(32'h44),32'h44,  32'h48,  0};
        tbl[20] = '{0, 1, 0, 0, 1, 32'h300,      JUNK,         1, 32'h200, I(32'h44),32'h44,  32'h48,  0};
        tbl[21] = '{0, 0, 0, 0, 1, 32'h0,        I(32'h300),   1, 32'h300, I(32'h44),32'h44,  32'h48,  0};
        tbl[22] = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         1, 32'h304, I(32'h300),32'h300,32'h304, 1};
        tbl[23] = '{0, 0, 1, 0, 1, 32'h0,        I(32'h304),   1, 32'h304, I(32'h300),32'h300,32'h304, 0};
        tbl[24] = '{0, 1, 1, 0, 0, 32'h80,       JUNK,         0, 32'h304, I(32'h300),32'h300,32'h304, 0};
        tbl[25] = '{0, 0, 0, 0, 0, 32'h0,        JUNK,         1, 32'h80,  I(32'h300),32'h300,32'h304, 0};

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst        = tbl[i].rst;
            PCsrc_E    = tbl[i].pcsrc;
            PCTarget_E = tbl[i].target;
            stall      = tbl[i].stall;
            flush_D    = tbl[i].flush;
            imem_ready = tbl[i].ready;
            imem_rdata = tbl[i].rdata;
            #1;
            chk_all($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_instr,
                    tbl[i].e_pcd, tbl[i].e_pc4, tbl[i].e_valid);
        end

        // Reset while a redirected request is still outstanding
        @(negedge clk);
        PCsrc_E = 1'b1; PCTarget_E = 32'h500; imem_ready = 1'b0;
        @(negedge clk);
        PCsrc_E = 1'b0;
        #1;
        chk("disc addr", imem_addr, 32'h80);
        chk("disc req", {31'd0, imem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst req", {31'd0, imem_req}, 32'd0);
        chk("rst addr", imem_addr, 32'h0);
        chk("rst instr", instr_D, NOP);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = I(32'h0);
        #1;
        chk("post-rst req", {31'd0, imem_req}, 32'd1);
        chk("post-rst addr", imem_addr, 32'h0);
        chk("post-rst valid", {31'd0, valid_D}, 32'd0);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        chk("post-rst instr", instr_D, I(32'h0));
        chk("post-rst PC_D", PC_D, 32'h0);
        chk("post-rst next addr", imem_addr, 32'h4);

        // Low target bits are masked and PC wraps past the top of the space
        @(negedge clk);
        PCsrc_E = 1'b1; PCTarget_E = 32'hFFFF_FFFF; imem_ready = 1'b1; imem_rdata = JUNK;
        @(negedge clk);
        PCsrc_E = 1'b0; imem_rdata = 32'h1234_5678;
        #1;
        chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        chk("wrap next addr", imem_addr, 32'h0);
        chk("wrap instr", instr_D, 32'h1234_5678);
        chk("wrap PC_D", PC_D, 32'hFFFF_FFFC);
        chk("wrap PC4_D", PCPlus4_D, 32'h0);
        chk("wrap valid", {31'd0, valid_D}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
